// File: rtl/sensor_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : sensor_frame_parser
// Description : CRC-8 checking parser for byte-serial sensor read frames.
//               It verifies one byte per cycle and reports words, errors and
//               frame completion.
// Revision    : 1.0  initial release
// ============================================================================

module sensor_frame_parser #(
    parameter int         NUM_WORDS     = 2,
    parameter int         WORD_BYTES    = 2,
    parameter logic [7:0] POLY          = 8'h31,
    parameter logic [7:0] CRC_INIT      = 8'hFF,
    parameter bit         STOP_ON_ERROR = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic [8*WORD_BYTES-1:0] word_data,
    output logic [3:0]              word_index,
    output logic                    word_valid,
    output logic                    crc_error,
    output logic                    frame_done,
    output logic                    frame_error,
    output logic                    busy,
    output logic [7:0]              err_count
);

    localparam int         WORD_W    = 8 * WORD_BYTES;
    localparam logic [2:0] LAST_BYTE = 3'(WORD_BYTES - 1);
    localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    // Byte-wide CRC step: the 8 bit iterations unroll into one XOR network.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    logic [1:0]        state_q,       state_d;
    logic [2:0]        byte_cnt_q,    byte_cnt_d;
    logic [3:0]        word_cnt_q,    word_cnt_d;
    logic [WORD_W-1:0] shift_q,       shift_d;
    logic [7:0]        crc_q,         crc_d;
    logic [WORD_W-1:0] word_data_q,   word_data_d;
    logic [3:0]        word_index_q,  word_index_d;
    logic              word_valid_q,  word_valid_d;
    logic              crc_error_q,   crc_error_d;
    logic              frame_done_q,  frame_done_d;
    logic              frame_error_q, frame_error_d;
    logic              busy_q,        busy_d;
    logic [7:0]        err_count_q,   err_count_d;

    logic              crc_match;

    assign crc_match = (byte_data == crc_q);

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        word_cnt_d    = word_cnt_q;
        shift_d       = shift_q;
        crc_d         = crc_q;
        word_data_d   = word_data_q;
        word_index_d  = word_index_q;
        word_valid_d  = 1'b0;
        crc_error_d   = 1'b0;
        frame_done_d  = 1'b0;
        frame_error_d = frame_error_q;
        err_count_d   = err_count_q;

        // frame_start overrides everything, including a byte in the same cycle.
        if (frame_start) begin
            state_d       = S_DATA;
            byte_cnt_d    = 3'd0;
            word_cnt_d    = 4'd0;
            shift_d       = '0;
            crc_d         = CRC_INIT;
            frame_error_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end

                S_DATA: begin
                    if (byte_valid) begin
                        shift_d = WORD_W'({shift_q, byte_data});
                        crc_d   = crc8_byte(crc_q, byte_data);
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = 3'd0;
                            state_d    = S_CHECK;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                        end
                    end
                end

                S_CHECK: begin
                    if (byte_valid) begin
                        if (crc_match) begin
                            word_data_d  = shift_q;
                            word_index_d = word_cnt_q;
                            word_valid_d = 1'b1;
                        end else begin
                            crc_error_d   = 1'b1;
                            frame_error_d = 1'b1;
                            if (err_count_q != 8'hFF) begin
                                err_count_d = err_count_q + 8'd1;
                            end
                        end

                        if (word_cnt_q == LAST_WORD) begin
                            frame_done_d = 1'b1;
                            state_d      = S_IDLE;
                        end else if (!crc_match && STOP_ON_ERROR) begin
                            state_d = S_IDLE;
                        end else begin
                            word_cnt_d = word_cnt_q + 4'd1;
                            crc_d      = CRC_INIT;
                            state_d    = S_DATA;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= 3'd0;
            word_cnt_q    <= 4'd0;
            shift_q       <= '0;
            crc_q         <= CRC_INIT;
            word_data_q   <= '0;
            word_index_q  <= 4'd0;
            word_valid_q  <= 1'b0;
            crc_error_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
            err_count_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            word_cnt_q    <= word_cnt_d;
            shift_q       <= shift_d;
            crc_q         <= crc_d;
            word_data_q   <= word_data_d;
            word_index_q  <= word_index_d;
            word_valid_q  <= word_valid_d;
            crc_error_q   <= crc_error_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
            err_count_q   <= err_count_d;
        end
    end

    assign word_data   = word_data_q;
    assign word_index  = word_index_q;
    assign word_valid  = word_valid_q;
    assign crc_error   = crc_error_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;
    assign err_count   = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sensor_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_frame_parser
// Description : Scoreboard bench for sensor_frame_parser (abort, continue and
//               single-byte-word configurations).
// Revision    : 1.0  initial release
// ============================================================================

module tb_sensor_frame_parser;

    localparam logic [3:0] EV_WV = 4'd1;
    localparam logic [3:0] EV_CE = 4'd2;
    localparam logic [3:0] EV_FD = 4'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // a: default (abort on error), b: continue on error; both share stimulus.
    logic        fs, bv;
    logic [7:0]  bd;
    logic [15:0] a_word_data, b_word_data;
    logic [3:0]  a_word_index, b_word_index;
    logic        a_word_valid, a_crc_error, a_frame_done, a_frame_error, a_busy;
    logic        b_word_valid, b_crc_error, b_frame_done, b_frame_error, b_busy;
    logic [7:0]  a_err_count, b_err_count;

    logic        s_fs, s_bv;
    logic [7:0]  s_bd;
    logic [7:0]  s_word_data;
    logic [3:0]  s_word_index;
    logic        s_word_valid, s_crc_error, s_frame_done, s_frame_error, s_busy;
    logic [7:0]  s_err_count;

    int n_cmp;
    int n_bad;

    logic [39:0] exp_q [3][$];
    logic [39:0] obs_q [3][$];

    sensor_frame_parser dut_a (
        .clk(clk), .rst(rst), .frame_start(fs), .byte_valid(bv), .byte_data(bd),
        .word_data(a_word_data), .word_index(a_word_index), .word_valid(a_word_valid),
        .crc_error(a_crc_error), .frame_done(a_frame_done), .frame_error(a_frame_error),
        .busy(a_busy), .err_count(a_err_count)
    );

    sensor_frame_parser #(.STOP_ON_ERROR(1'b0)) dut_b (
        .clk(clk), .rst(rst), .frame_start(fs), .byte_valid(bv), .byte_data(bd),
        .word_data(b_word_data), .word_index(b_word_index), .word_valid(b_word_valid),
        .crc_error(b_crc_error), .frame_done(b_frame_done), .frame_error(b_frame_error),
        .busy(b_busy), .err_count(b_err_count)
    );

    sensor_frame_parser #(.NUM_WORDS(1), .WORD_BYTES(1)) dut_s (
        .clk(clk), .rst(rst), .frame_start(s_fs), .byte_valid(s_bv), .byte_data(s_bd),
        .word_data(s_word_data), .word_index(s_word_index), .word_valid(s_word_valid),
        .crc_error(s_crc_error), .frame_done(s_frame_done), .frame_error(s_frame_error),
        .busy(s_busy), .err_count(s_err_count)
    );

    // Output pulses are captured as events, word/error before frame_done.
    always @(negedge clk) begin
        if (a_word_valid) obs_q[0].push_back({EV_WV, a_word_index, 32'(a_word_data)});
        if (a_crc_error)  obs_q[0].push_back({EV_CE, 36'h0});
        if (a_frame_done) obs_q[0].push_back({EV_FD, 36'h0});
        if (b_word_valid) obs_q[1].push_back({EV_WV, b_word_index, 32'(b_word_data)});
        if (b_crc_error)  obs_q[1].push_back({EV_CE, 36'h0});
        if (b_frame_done) obs_q[1].push_back({EV_FD, 36'h0});
        if (s_word_valid) obs_q[2].push_back({EV_WV, s_word_index, 32'(s_word_data)});
        if (s_crc_error)  obs_q[2].push_back({EV_CE, 36'h0});
        if (s_frame_done) obs_q[2].push_back({EV_FD, 36'h0});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Bit-serial reference CRC over the low nbytes of data, MSB first.
    function automatic logic [7:0] crc_model(input logic [31:0] data, input int nbytes);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        for (int i = nbytes * 8 - 1; i >= 0; i--) begin
            fb = c[7] ^ data[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h31;
        end
        return c;
    endfunction

    function automatic logic [39:0] ev_word(input logic [3:0] idx, input logic [31:0] d);
        return {EV_WV, idx, d};
    endfunction

    task automatic drive(input logic f, input logic v, input logic [7:0] d);
        fs = f; bv = v; bd = d;
        @(posedge clk); #1;
        fs = 1'b0; bv = 1'b0; bd = 8'h00;
    endtask

    task automatic sdrive(input logic f, input logic v, input logic [7:0] d);
        s_fs = f; s_bv = v; s_bd = d;
        @(posedge clk); #1;
        s_fs = 1'b0; s_bv = 1'b0; s_bd = 8'h00;
    endtask

    task automatic send_words(input logic [15:0] w0, input logic [15:0] w1);
        drive(1'b0, 1'b1, w0[15:8]);
        drive(1'b0, 1'b1, w0[7:0]);
        drive(1'b0, 1'b1, crc_model(32'(w0), 2));
        drive(1'b0, 1'b1, w1[15:8]);
        drive(1'b0, 1'b1, w1[7:0]);
        drive(1'b0, 1'b1, crc_model(32'(w1), 2));
    endtask

    task automatic push_ab(input logic [39:0] ev);
        exp_q[0].push_back(ev);
        exp_q[1].push_back(ev);
    endtask

    task automatic test_reset;
        logic [39:0] e, o;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({a_word_data, a_word_index, a_word_valid, a_crc_error, a_frame_done,
             a_frame_error, a_busy, a_err_count} !== 35'h0) begin
            n_bad++; $display("FAIL reset_a: outputs %h, expected all zero",
                {a_word_data, a_word_index, a_word_valid, a_crc_error, a_frame_done,
                 a_frame_error, a_busy, a_err_count});
        end
        n_cmp++;
        if ({s_word_data, s_word_index, s_word_valid, s_crc_error, s_frame_done,
             s_frame_error, s_busy, s_err_count} !== 27'h0) begin
            n_bad++; $display("FAIL reset_s: outputs %h, expected all zero",
                {s_word_data, s_word_index, s_word_valid, s_crc_error, s_frame_done,
                 s_frame_error, s_busy, s_err_count});
        end
        rst = 1'b0;
        // Bytes without frame_start must be ignored.
        drive(1'b0, 1'b1, 8'hBE);
        drive(1'b0, 1'b1, 8'hEF);
        drive(1'b0, 1'b1, 8'h92);
        drive(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (a_busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_bytes_busy: got %b expected 0", a_busy);
        end
        for (int k = 0; k < 3; k++) begin
            while (exp_q[k].size() > 0) begin
                e = exp_q[k].pop_front();
                o = 40'hFF_FFFF_FFFF;
                if (obs_q[k].size() > 0) o = obs_q[k].pop_front();
                n_cmp++;
                if (o !== e) begin n_bad++; $display("FAIL reset_event dut%0d: got %h expected %h", k, o, e); end
            end
            n_cmp++;
            if (obs_q[k].size() != 0) begin
                n_bad++; $display("FAIL reset_extra dut%0d: got %0d events expected 0", k, obs_q[k].size());
                obs_q[k].delete();
            end
        end
    endtask

    task automatic test_good_frame;
        logic [39:0] e, o;
        push_ab(ev_word(4'd0, 32'h0000_BEEF));
        push_ab(ev_word(4'd1, 32'h0000_6666));
        push_ab({EV_FD, 36'h0});
        drive(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (a_busy !== 1'b1) begin n_bad++; $display("FAIL good_busy_start: got %b expected 1", a_busy); end
        drive(1'b0, 1'b1, 8'hBE);
        drive(1'b0, 1'b1, 8'hEF);
        drive(1'b0, 1'b1, 8'h92);
        n_cmp++;
        if (a_word_valid !== 1'b1) begin n_bad++; $display("FAIL good_wv0_timing: got %b expected 1", a_word_valid); end
        drive(1'b0, 1'b1, 8'h66);
        drive(1'b0, 1'b1, 8'h66);
        drive(1'b0, 1'b1, 8'h93);
        n_cmp++;
        if ({a_word_valid, a_frame_done, a_busy} !== 3'b110) begin
            n_bad++; $display("FAIL good_last_timing: wv/fd/busy got %b expected 110",
                {a_word_valid, a_frame_done, a_busy});
        end
        drive(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if ({a_word_valid, a_frame_done, a_frame_error, a_err_count} !== 11'h0) begin
            n_bad++; $display("FAIL good_after: wv/fd/ferr/errcnt got %h expected 0",
                {a_word_valid, a_frame_done, a_frame_error, a_err_count});
        end
        drive(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            while (exp_q[k].size() > 0) begin
                e = exp_q[k].pop_front();
                o = 40'hFF_FFFF_FFFF;
                if (obs_q[k].size() > 0) o = obs_q[k].pop_front();
                n_cmp++;
                if (o !== e) begin n_bad++; $display("FAIL good_event dut%0d: got %h expected %h", k, o, e); end
            end
            n_cmp++;
            if (obs_q[k].size() != 0) begin
                n_bad++; $display("FAIL good_extra dut%0d: got %0d events expected 0", k, obs_q[k].size());
                obs_q[k].delete();
            end
        end
    endtask

    task automatic test_crc_error;
        logic [39:0] e, o;
        exp_q[0].push_back({EV_CE, 36'h0});
        exp_q[1].push_back({EV_CE, 36'h0});
        exp_q[1].push_back(ev_word(4'd1, 32'h0000_6666));
        exp_q[1].push_back({EV_FD, 36'h0});
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'hBE);
        drive(1'b0, 1'b1, 8'hEF);
        drive(1'b0, 1'b1, 8'h93);
        n_cmp++;
        if ({a_crc_error, a_frame_error, a_busy, a_err_count} !== {3'b110, 8'd1}) begin
            n_bad++; $display("FAIL abort_flags: ce/ferr/busy/errcnt got %h expected %h",
                {a_crc_error, a_frame_error, a_busy, a_err_count}, {3'b110, 8'd1});
        end
        n_cmp++;
        if (b_busy !== 1'b1) begin n_bad++; $display("FAIL cont_busy: got %b expected 1", b_busy); end
        drive(1'b0, 1'b1, 8'h66);
        drive(1'b0, 1'b1, 8'h66);
        drive(1'b0, 1'b1, 8'h93);
        n_cmp++;
        if ({b_frame_done, b_frame_error, b_err_count} !== {2'b11, 8'd1}) begin
            n_bad++; $display("FAIL cont_done: fd/ferr/errcnt got %h expected %h",
                {b_frame_done, b_frame_error, b_err_count}, {2'b11, 8'd1});
        end
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if ({a_frame_error, a_word_data, a_busy} !== {1'b1, 16'h6666, 1'b0}) begin
            n_bad++; $display("FAIL abort_hold: ferr/data/busy got %h expected %h",
                {a_frame_error, a_word_data, a_busy}, {1'b1, 16'h6666, 1'b0});
        end
        for (int k = 0; k < 3; k++) begin
            while (exp_q[k].size() > 0) begin
                e = exp_q[k].pop_front();
                o = 40'hFF_FFFF_FFFF;
                if (obs_q[k].size() > 0) o = obs_q[k].pop_front();
                n_cmp++;
                if (o !== e) begin n_bad++; $display("FAIL crcerr_event dut%0d: got %h expected %h", k, o, e); end
            end
            n_cmp++;
            if (obs_q[k].size() != 0) begin
                n_bad++; $display("FAIL crcerr_extra dut%0d: got %0d events expected 0", k, obs_q[k].size());
                obs_q[k].delete();
            end
        end
    endtask

    task automatic test_restart;
        logic [39:0] e, o;
        drive(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if ({a_frame_error, b_frame_error} !== 2'b00) begin
            n_bad++; $display("FAIL restart_ferr_clear: got %b expected 00", {a_frame_error, b_frame_error});
        end
        drive(1'b0, 1'b1, 8'hBE);
        drive(1'b0, 1'b1, 8'hEF);
        // Restart together with a byte: the byte must be dropped.
        drive(1'b1, 1'b1, 8'h92);
        push_ab(ev_word(4'd0, 32'h0000_1234));
        push_ab(ev_word(4'd1, 32'h0000_ABCD));
        push_ab({EV_FD, 36'h0});
        send_words(16'h1234, 16'hABCD);
        drive(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if ({a_err_count, b_err_count, a_frame_error, b_frame_error} !== {8'd1, 8'd1, 2'b00}) begin
            n_bad++; $display("FAIL restart_counts: got %h expected %h",
                {a_err_count, b_err_count, a_frame_error, b_frame_error}, {8'd1, 8'd1, 2'b00});
        end
        for (int k = 0; k < 3; k++) begin
            while (exp_q[k].size() > 0) begin
                e = exp_q[k].pop_front();
                o = 40'hFF_FFFF_FFFF;
                if (obs_q[k].size() > 0) o = obs_q[k].pop_front();
                n_cmp++;
                if (o !== e) begin n_bad++; $display("FAIL restart_event dut%0d: got %h expected %h", k, o, e); end
            end
            n_cmp++;
            if (obs_q[k].size() != 0) begin
                n_bad++; $display("FAIL restart_extra dut%0d: got %0d events expected 0", k, obs_q[k].size());
                obs_q[k].delete();
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [39:0] e, o;
        logic [15:0] w0, w1;
        for (int f = 0; f < 4; f++) begin
            w0 = 16'($urandom);
            w1 = 16'($urandom);
            push_ab(ev_word(4'd0, 32'(w0)));
            push_ab(ev_word(4'd1, 32'(w1)));
            push_ab({EV_FD, 36'h0});
            drive(1'b1, 1'b0, 8'h00);
            send_words(w0, w1);
        end
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if ({a_busy, a_err_count} !== {1'b0, 8'd1}) begin
            n_bad++; $display("FAIL b2b_end: busy/errcnt got %h expected %h", {a_busy, a_err_count}, {1'b0, 8'd1});
        end
        for (int k = 0; k < 3; k++) begin
            while (exp_q[k].size() > 0) begin
                e = exp_q[k].pop_front();
                o = 40'hFF_FFFF_FFFF;
                if (obs_q[k].size() > 0) o = obs_q[k].pop_front();
                n_cmp++;
                if (o !== e) begin n_bad++; $display("FAIL b2b_event dut%0d: got %h expected %h", k, o, e); end
            end
            n_cmp++;
            if (obs_q[k].size() != 0) begin
                n_bad++; $display("FAIL b2b_extra dut%0d: got %0d events expected 0", k, obs_q[k].size());
                obs_q[k].delete();
            end
        end
    endtask

    task automatic test_single_byte;
        logic [39:0] e, o;
        logic [7:0]  d, bad;
        int          exp_cnt;
        for (int f = 0; f < 40; f++) begin
            d = 8'($urandom);
            exp_q[2].push_back(ev_word(4'd0, 32'(d)));
            exp_q[2].push_back({EV_FD, 36'h0});
            sdrive(1'b1, 1'b0, 8'h00);
            repeat ($urandom_range(0, 5)) sdrive(1'b0, 1'b0, 8'h00);
            sdrive(1'b0, 1'b1, d);
            repeat ($urandom_range(0, 5)) sdrive(1'b0, 1'b0, 8'h00);
            sdrive(1'b0, 1'b1, crc_model(32'(d), 1));
            // Surplus bytes after the frame land in IDLE and are ignored.
            repeat ($urandom_range(0, 5)) sdrive(1'b0, 1'b1, 8'($urandom));
        end
        n_cmp++;
        if (s_err_count !== 8'd0) begin n_bad++; $display("FAIL single_good_errcnt: got %0d expected 0", s_err_count); end
        exp_cnt = 0;
        for (int f = 0; f < 300; f++) begin
            d   = 8'($urandom);
            bad = crc_model(32'(d), 1) ^ 8'($urandom_range(1, 255));
            exp_q[2].push_back({EV_CE, 36'h0});
            exp_q[2].push_back({EV_FD, 36'h0});
            sdrive(1'b1, 1'b0, 8'h00);
            sdrive(1'b0, 1'b1, d);
            sdrive(1'b0, 1'b1, bad);
            if (exp_cnt < 255) exp_cnt++;
            if (f == 99) begin
                n_cmp++;
                if (s_err_count !== 8'(exp_cnt)) begin
                    n_bad++; $display("FAIL single_errcnt_mid: got %0d expected %0d", s_err_count, exp_cnt);
                end
            end
        end
        sdrive(1'b0, 1'b0, 8'h00);
        sdrive(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if ({s_err_count, s_frame_error} !== {8'(exp_cnt), 1'b1}) begin
            n_bad++; $display("FAIL single_saturate: errcnt/ferr got %h expected %h",
                {s_err_count, s_frame_error}, {8'(exp_cnt), 1'b1});
        end
        for (int k = 0; k < 3; k++) begin
            while (exp_q[k].size() > 0) begin
                e = exp_q[k].pop_front();
                o = 40'hFF_FFFF_FFFF;
                if (obs_q[k].size() > 0) o = obs_q[k].pop_front();
                n_cmp++;
                if (o !== e) begin n_bad++; $display("FAIL single_event dut%0d: got %h expected %h", k, o, e); end
            end
            n_cmp++;
            if (obs_q[k].size() != 0) begin
                n_bad++; $display("FAIL single_extra dut%0d: got %0d events expected 0", k, obs_q[k].size());
                obs_q[k].delete();
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [39:0] e, o;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'hBE);
        drive(1'b0, 1'b1, 8'hEF);
        n_cmp++;
        if ({a_busy, a_word_data} !== {1'b1, 16'h0000} && a_busy !== 1'b1) begin
            n_bad++; $display("FAIL midrst_pre_busy: got %b expected 1", a_busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_word_data, a_word_index, a_word_valid, a_crc_error, a_frame_done,
             a_frame_error, a_busy, a_err_count} !== 35'h0) begin
            n_bad++; $display("FAIL midrst_a: outputs %h expected all zero",
                {a_word_data, a_word_index, a_busy, a_err_count});
        end
        n_cmp++;
        if ({b_word_data, b_busy, b_err_count, b_frame_error} !== 26'h0) begin
            n_bad++; $display("FAIL midrst_b: outputs %h expected all zero",
                {b_word_data, b_busy, b_err_count, b_frame_error});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b1, 8'h92);
        drive(1'b0, 1'b1, 8'h66);
        drive(1'b0, 1'b1, 8'h66);
        drive(1'b0, 1'b1, 8'h93);
        drive(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if ({a_busy, a_word_data, a_err_count} !== 25'h0) begin
            n_bad++; $display("FAIL midrst_ignore: busy/data/errcnt got %h expected 0",
                {a_busy, a_word_data, a_err_count});
        end
        for (int k = 0; k < 3; k++) begin
            while (exp_q[k].size() > 0) begin
                e = exp_q[k].pop_front();
                o = 40'hFF_FFFF_FFFF;
                if (obs_q[k].size() > 0) o = obs_q[k].pop_front();
                n_cmp++;
                if (o !== e) begin n_bad++; $display("FAIL midrst_event dut%0d: got %h expected %h", k, o, e); end
            end
            n_cmp++;
            if (obs_q[k].size() != 0) begin
                n_bad++; $display("FAIL midrst_extra dut%0d: got %0d events expected 0", k, obs_q[k].size());
                obs_q[k].delete();
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        fs    = 1'b0; bv   = 1'b0; bd   = 8'h00;
        s_fs  = 1'b0; s_bv = 1'b0; s_bd = 8'h00;
        test_reset;
        test_good_frame;
        test_crc_error;
        test_restart;
        test_back_to_back;
        test_single_byte;
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sensor_frame_parser.md
# sensor_frame_parser

Parametrised receive-side parser for CRC-protected sensor read frames (SHT4x-style) arriving byte-by-byte from the I2C master's read path. A frame is NUM_WORDS words, each WORD_BYTES data bytes (MSB first) followed by one CRC-8 byte. The block checks every CRC with one byte per cycle of throughput, presents each verified word with its index, and reports frame completion and errors back to the master and the measurement logic.

## Interface
Parameters:
- NUM_WORDS, 2, words per frame (1..15); SHT40 T+RH = 2
- WORD_BYTES, 2, data bytes per word (1..4)
- POLY, 8'h31, CRC-8 polynomial (x^8 implicit)
- CRC_INIT, 8'hFF, CRC seed loaded at the start of every word
- STOP_ON_ERROR, 1, 1: CRC error aborts the frame; 0: continue with the next word

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse; master is about to deliver a new frame
- byte_valid  in  1  byte_data holds a received byte this cycle
- byte_data  in  8  received byte
- word_data  out  8*WORD_BYTES  last verified word, MSB = first byte received
- word_index  out  4  index (0..NUM_WORDS-1) of word_data
- word_valid  out  1  one-cycle pulse: word_data/word_index updated, CRC good
- crc_error  out  1  one-cycle pulse: received CRC byte mismatched
- frame_done  out  1  one-cycle pulse: last CRC byte of the frame accepted (good or bad, if not aborted)
- frame_error  out  1  sticky; set by any CRC error in the current frame, cleared by frame_start
- busy  out  1  high while in DATA or CHECK
- err_count  out  8  saturating count of CRC errors since reset

## Operation
- States: IDLE, DATA, CHECK. Reset and frame_start clear byte counter, word counter and shift register, and load crc = CRC_INIT.
- IDLE: byte_valid ignored. frame_start -> DATA.
- DATA: each byte_valid shifts byte_data into the word shift register and updates crc; after the WORD_BYTES-th byte -> CHECK.
- CRC update per byte: crc ^= byte; then 8 iterations of crc = crc[7] ? (crc<<1)^POLY : crc<<1 (8-bit result). Fully unrolled, combinational, single cycle.
- CHECK: next byte_valid is the CRC byte, compared with the running crc.
  - Match: word_data <= shift register, word_index <= word counter, word_valid pulse.
  - Mismatch: crc_error pulse, frame_error set, err_count +1 (holds at 255); word_data/word_index unchanged.
  - Not last word (counter < NUM_WORDS-1): counter +1, crc = CRC_INIT, -> DATA; on mismatch with STOP_ON_ERROR=1 -> IDLE instead, no frame_done.
  - Last word: frame_done pulse, -> IDLE.
- frame_start in DATA/CHECK: partial frame discarded silently (no pulses), restart in DATA. frame_start coincident with byte_valid: frame_start wins, byte dropped.
- Bytes in IDLE (surplus bytes, or after abort) are ignored; no counters change.

## Timing
- Reset values: word_data 0, word_index 0, word_valid 0, crc_error 0, frame_done 0, frame_error 0, busy 0, err_count 0, state IDLE.
- All outputs registered. word_valid/crc_error/frame_done assert in the cycle after the clock edge that accepted the CRC byte; each pulse lasts exactly one cycle.
- Throughput: byte_valid may be high every cycle; back-to-back frames allowed (frame_start the cycle after frame_done).
- busy high from the cycle after frame_start until the cycle after the final CRC byte or abort.
- frame_error clears in the cycle after frame_start and holds otherwise; an error on the last word sets it in the same cycle as crc_error/frame_done.
- rst asserted mid-frame: all state to reset values immediately; no pulses emitted.

## Test plan
- Default params, frame_start then bytes BE EF 92 66 66 93 on consecutive cycles -> word_valid idx0 data 16'hBEEF, then idx1 16'h6666, frame_done with idx1 pulse, frame_error 0, err_count 0.
- Same frame with first CRC 0x93, STOP_ON_ERROR=1 -> crc_error pulse, frame_error 1, err_count 1, busy drops, remaining 3 bytes ignored, no frame_done, word_valid never pulses.
- STOP_ON_ERROR=0, same corrupted frame -> crc_error for word0, word_valid idx1 16'h6666, frame_done, frame_error stays 1 until next frame_start.
- frame_start after 2 bytes of a frame, then full good frame -> no pulses from the partial frame; good frame parses normally.
- NUM_WORDS=1, WORD_BYTES=1, byte_valid gaps of 0-5 random cycles, random data with golden-model CRC -> word_valid per frame, matching data; 300 forced bad CRCs -> err_count saturates at 255.
- rst pulse while in CHECK -> all outputs 0 next cycle, subsequent byte_valid ignored until frame_start.
